// File: rtl/ram2_reader.sv
// ram2_reader: reads num_rows packed rows from an external RAM and streams num_feat features plus y per row.
// Defining RAM2_READER_PREFETCH_EN adds a second row buffer that fetches row r+1 while row r streams.
module ram2_reader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH*(MAX_FEATURES+1),
  parameter int DEPTH        = 100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  input  logic [3:0]            num_feat,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_oe,
  output logic                  ram_we,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic [LENGTH-1:0]     out_data,
  output logic [3:0]            out_idx,
  output logic                  out_is_y,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_RD     = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] rows_q, rows_d;
  logic [3:0]            nfeat_q, nfeat_d;
  logic [3:0]            beat_q, beat_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_oe_q, ram_oe_d;
  logic [LENGTH-1:0]     out_data_q, out_data_d;
  logic [3:0]            out_idx_q, out_idx_d;
  logic                  out_is_y_q, out_is_y_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef RAM2_READER_PREFETCH_EN
  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_ADDR = 2'd1,
    PF_RD   = 2'd2,
    PF_FULL = 2'd3
  } pf_t;

  pf_t                   pf_q, pf_d;
  logic [DATA_WIDTH-1:0] pbuf_q, pbuf_d;
`endif

  // beat presentation request, shared by the row-start and next-beat paths
  logic                  present_s;
  logic [3:0]            beat_k_s;
  logic [ADDR_WIDTH-1:0] beat_row_s;
  logic [DATA_WIDTH-1:0] beat_src_s;
  logic                  is_y_s;
  logic                  more_rows_s;

  function automatic logic [LENGTH-1:0] field(input logic [DATA_WIDTH-1:0] row,
                                              input logic [3:0] k);
    return row[LENGTH*k +: LENGTH];
  endfunction

  // next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rows_d      = rows_q;
    nfeat_d     = nfeat_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    ram_addr_d  = ram_addr_q;
    ram_oe_d    = ram_oe_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_is_y_d  = out_is_y_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    present_s   = 1'b0;
    beat_k_s    = 4'd0;
    beat_row_s  = row_q;
    beat_src_s  = buf_q;
    more_rows_s = (row_q + ADDR_WIDTH'(1)) < rows_q;

`ifdef RAM2_READER_PREFETCH_EN
    pf_d   = pf_q;
    pbuf_d = pbuf_q;
    if (state_q == S_STREAM) begin
      case (pf_q)
        PF_IDLE: begin
          if (more_rows_s) begin
            pf_d       = PF_ADDR;
            ram_addr_d = row_q + ADDR_WIDTH'(1);
            ram_oe_d   = 1'b1;
          end else begin
            pf_d = PF_IDLE;
          end
        end
        PF_ADDR: pf_d = PF_RD;
        PF_RD: begin
          pf_d     = PF_FULL;
          pbuf_d   = ram_data;
          ram_oe_d = 1'b0;
        end
        PF_FULL: pf_d = PF_FULL;
        default: pf_d = PF_IDLE;
      endcase
    end else begin
      pf_d = PF_IDLE;
    end
`endif

    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        ram_oe_d = 1'b0;
        if (start) begin
          rows_d  = (num_rows > ADDR_WIDTH'(DEPTH)) ? ADDR_WIDTH'(DEPTH) : num_rows;
          nfeat_d = ({1'b0, num_feat} > 5'(MAX_FEATURES)) ? 4'(MAX_FEATURES) : num_feat;
          row_d   = '0;
          busy_d  = 1'b1;
          if (num_rows == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ADDR;
            ram_addr_d = '0;
            ram_oe_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: state_d = S_RD;
      S_RD: begin
        state_d    = S_STREAM;
        buf_d      = ram_data;
        ram_oe_d   = 1'b0;
        present_s  = 1'b1;
        beat_src_s = ram_data;
      end
      S_STREAM: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_is_y_d  = 1'b0;
          out_last_d  = 1'b0;
          if (!out_is_y_q) begin
            present_s = 1'b1;
            beat_k_s  = beat_q + 4'd1;
          end else if (more_rows_s) begin
            row_d = row_q + ADDR_WIDTH'(1);
`ifdef RAM2_READER_PREFETCH_EN
            // a fetch still in its RD phase lands this very edge, so take it straight off the bus
            if (pf_q == PF_FULL || pf_q == PF_RD) begin
              beat_src_s = (pf_q == PF_FULL) ? pbuf_q : ram_data;
              buf_d      = beat_src_s;
              beat_row_s = row_q + ADDR_WIDTH'(1);
              present_s  = 1'b1;
              pf_d       = PF_IDLE;
              ram_oe_d   = 1'b0;
            end else if (pf_q == PF_ADDR) begin
              state_d = S_RD;
              pf_d    = PF_IDLE;
            end else begin
              state_d    = S_ADDR;
              ram_addr_d = row_q + ADDR_WIDTH'(1);
              ram_oe_d   = 1'b1;
              pf_d       = PF_IDLE;
            end
`else
            state_d    = S_ADDR;
            ram_addr_d = row_q + ADDR_WIDTH'(1);
            ram_oe_d   = 1'b1;
`endif
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            ram_oe_d = 1'b0;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        ram_oe_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    is_y_s      = (beat_k_s == nfeat_q);
    out_valid_d = present_s ? 1'b1 : out_valid_d;
    beat_d      = present_s ? beat_k_s : beat_d;
    out_is_y_d  = present_s ? is_y_s : out_is_y_d;
    out_idx_d   = present_s ? (is_y_s ? 4'(MAX_FEATURES) : beat_k_s) : out_idx_d;
    out_data_d  = present_s ? field(beat_src_s, out_idx_d) : out_data_d;
    out_last_d  = present_s ? (is_y_s && (beat_row_s == rows_q - ADDR_WIDTH'(1))) : out_last_d;
  end

  // state and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      rows_q      <= '0;
      nfeat_q     <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      ram_addr_q  <= '0;
      ram_oe_q    <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_is_y_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RAM2_READER_PREFETCH_EN
      pf_q        <= PF_IDLE;
      pbuf_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      rows_q      <= rows_d;
      nfeat_q     <= nfeat_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      ram_addr_q  <= ram_addr_d;
      ram_oe_q    <= ram_oe_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_is_y_q  <= out_is_y_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef RAM2_READER_PREFETCH_EN
      pf_q        <= pf_d;
      pbuf_q      <= pbuf_d;
`endif
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_oe    = ram_oe_q;
  assign ram_we    = 1'b0;
  assign ram_data  = {DATA_WIDTH{1'bz}};
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_is_y  = out_is_y_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram2_reader.sv
// Scoreboard bench for ram2_reader: expected beats are queued from a row-level model,
// a negedge monitor pops and compares every transferred beat.
`timescale 1ns/1ps
module tb_ram2_reader;
  localparam int AW    = 12;
  localparam int MF    = 15;
  localparam int L     = 16;
  localparam int DW    = L*(MF+1);
  localparam int DEPTH = 100;
`ifdef RAM2_READER_PREFETCH_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 2;
`endif

  logic          CLK = 1'b0;
  logic          RST, start, out_ready;
  logic [AW-1:0] num_rows;
  logic [3:0]    num_feat;
  logic [AW-1:0] ram_addr;
  logic          ram_oe, ram_we;
  wire  [DW-1:0] ram_data;
  logic [L-1:0]  out_data;
  logic [3:0]    out_idx;
  logic          out_is_y, out_last, out_valid, busy, done;

  logic [DW-1:0] mem [DEPTH];

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        is_y;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  bit    pat_q[$];
  int    gaps[$];
  int    n_vec = 0, n_fail = 0;
  int    ready_mode = 0;
  int    done_cnt = 0, max_addr = 0, n_xfer = 0, gap = 0;
  bit    oe_seen = 0, prev_hold = 0, in_gap = 0, prev_done = 0;
  beat_t prev_b;

  ram2_reader dut (
    .CLK(CLK), .RST(RST), .start(start), .num_rows(num_rows), .num_feat(num_feat),
    .ram_addr(ram_addr), .ram_oe(ram_oe), .ram_we(ram_we), .ram_data(ram_data),
    .out_data(out_data), .out_idx(out_idx), .out_is_y(out_is_y), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  assign ram_data = ram_oe ? ((ram_addr < AW'(DEPTH)) ? mem[ram_addr[6:0]] : '0) : {DW{1'bz}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  32'(ram_addr), 32'd0);
    check({tag, "_oe"},    32'(ram_oe), 32'd0);
    check({tag, "_data"},  32'(out_data), 32'd0);
    check({tag, "_idx"},   32'(out_idx), 32'd0);
    check({tag, "_isy"},   32'(out_is_y), 32'd0);
    check({tag, "_last"},  32'(out_last), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
  endtask

  // reference model: every row streams min(feat,15) features then y
  task automatic push_expected(input int rows, input int feat);
    int r_eff = (rows > DEPTH) ? DEPTH : rows;
    int f_eff = (feat > MF) ? MF : feat;
    for (int r = 0; r < r_eff; r++) begin
      for (int k = 0; k <= f_eff; k++) begin
        beat_t e;
        logic [DW-1:0] row;
        int slot;
        row    = mem[r];
        slot   = (k == f_eff) ? MF : k;
        e.data = row[L*slot +: L];
        e.idx  = 4'(slot);
        e.is_y = (k == f_eff);
        e.last = (k == f_eff) && (r == r_eff - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // scoreboard monitor and per-cycle protocol checks
  always @(negedge CLK) begin
    beat_t b;
    beat_t e;
    b = {out_data, out_idx, out_is_y, out_last};
    check("ram_we", 32'(ram_we), 32'd0);
    if (!RST) begin
      if (ram_oe) begin
        oe_seen = 1;
        if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        check("addr_range", 32'(ram_addr < AW'(DEPTH)), 32'd1);
      end
      if (out_valid || ram_oe) check("busy_active", 32'(busy), 32'd1);
      if (done) begin
        done_cnt++;
        check("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = done;
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_beat", 32'(b), 32'(prev_b));
      end
      if (in_gap) begin
        if (out_valid) begin
          gaps.push_back(gap);
          in_gap = 0;
        end else begin
          gap++;
        end
      end
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(b), 32'(e));
        end
        if (out_is_y && !out_last) begin
          in_gap = 1;
          gap = 0;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_b = b;
    end else begin
      prev_hold = 0;
      in_gap = 0;
      prev_done = 0;
    end
  end

  // consumer ready: always, random, or a pattern applied on valid cycles
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && pat_q.size() > 0) out_ready = pat_q.pop_front();
          else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // mode 1: latency checks, mode 2: empty pass checks
  task automatic run_pass(input int rows, input int feat, input int mode);
    int cyc;
    push_expected(rows, feat);
    done_cnt = 0; oe_seen = 0; max_addr = 0; n_xfer = 0;
    gaps.delete();
    @(posedge CLK); #1;
    num_rows = AW'(rows);
    num_feat = 4'(feat);
    start = 1'b1;
    @(negedge CLK);
    if (mode == 1) check("oe_cycle0", 32'(ram_oe), 32'd0);
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    if (mode == 1) begin
      check("oe_cycle1", 32'(ram_oe), 32'd1);
      check("addr_cycle1", 32'(ram_addr), 32'd0);
    end
    if (mode == 2) check("done_cycle1", 32'(done), 32'd1);
    @(negedge CLK);
    if (mode == 1) check("valid_cycle2", 32'(out_valid), 32'd0);
    @(negedge CLK);
    if (mode == 1) check("valid_cycle3", 32'(out_valid), 32'd1);
    cyc = 0;
    while (cyc < 20000 && !(busy == 1'b0 && done_cnt > 0)) begin
      @(negedge CLK);
      cyc++;
    end
    check("pass_end_busy", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("beats_left", 32'(exp_q.size()), 32'd0);
    if (mode == 2) check("oe_seen_empty", 32'(oe_seen), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    RST = 1'b1; start = 1'b0; num_rows = '0; num_feat = '0;
    for (int r = 0; r < DEPTH; r++)
      for (int w = 0; w < DW/32; w++) mem[r][32*w +: 32] = $urandom();
    @(posedge CLK); @(negedge CLK);
    check_zero("reset");
    @(posedge CLK); #1; RST = 1'b0;

    for (int k = 0; k < MF; k++) mem[0][L*k +: L] = 16'(k);
    mem[0][L*MF +: L] = 16'hAAAA;
    run_pass(1, 3, 1);

    run_pass(3, 2, 0);
    check("gap_count", 32'(gaps.size()), 32'd2);
    foreach (gaps[i]) check("row_gap", 32'(gaps[i]), 32'(EXP_GAP));

    ready_mode = 2;
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_pass(2, 3, 0);
    ready_mode = 0;

    run_pass(0, 5, 2);
    run_pass(200, 1, 0);
    check("max_addr_clamp", 32'(max_addr), 32'(DEPTH - 1));

    for (int p = 0; p < 8; p++) begin
      int rr = $urandom_range(0, 6);
      for (int w = 0; w < DW/32; w++) mem[p][32*w +: 32] = $urandom();
      ready_mode = $urandom_range(0, 1);
      run_pass(rr, $urandom_range(0, 15), 0);
    end
    ready_mode = 0;

    // reset while the second beat of row 1 is pending
    push_expected(3, 2);
    n_xfer = 0;
    @(posedge CLK); #1;
    num_rows = AW'(3); num_feat = 4'(2); start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(n_xfer == 4 && out_valid)) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check("rst_target_idx", 32'(out_idx), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check_zero("midpass_reset");
    run_pass(2, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
